// File: rtl/vga_pkg.sv
// Shared types and helpers for the VGA stream output block.
package vga_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_ARMED = 2'd2,
        ST_RUN   = 2'd3
    } vga_state_e;

    localparam int NUM_BARS = 8;

    // Classic colour-bar order, left to right, as 24-bit RGB.
    localparam logic [23:0] BAR_COLOURS [NUM_BARS] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        return BAR_COLOURS[idx];
    endfunction

    function automatic int total_len(input int fp, input int pulse, input int bp, input int disp);
        return fp + pulse + bp + disp;
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Raster counters for vga_stream_out: porch/sync/active decode and active-area coordinates.
module vga_timing
    import vga_pkg::*;
#(
    parameter int HDISP  = 800,
    parameter int VDISP  = 480,
    parameter int HFP    = 40,
    parameter int HPULSE = 48,
    parameter int HBP    = 40,
    parameter int VFP    = 13,
    parameter int VPULSE = 3,
    parameter int VBP    = 29,
    parameter int XW     = (HDISP > 1) ? $clog2(HDISP) : 1,
    parameter int YW     = (VDISP > 1) ? $clog2(VDISP) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    output logic          hsync_o,
    output logic          vsync_o,
    output logic          active_o,
    output logic          origin_o,
    output logic          first_px_o,
    output logic [XW-1:0] x_o,
    output logic [YW-1:0] y_o
);

    localparam int HTOT = total_len(HFP, HPULSE, HBP, HDISP);
    localparam int VTOT = total_len(VFP, VPULSE, VBP, VDISP);
    localparam int HCW  = $clog2(HTOT);
    localparam int VCW  = $clog2(VTOT);

    localparam logic [HCW-1:0] H_LAST   = HCW'(HTOT - 1);
    localparam logic [HCW-1:0] H_SYNC_B = HCW'(HFP);
    localparam logic [HCW-1:0] H_SYNC_E = HCW'(HFP + HPULSE);
    localparam logic [HCW-1:0] H_ACT    = HCW'(HFP + HPULSE + HBP);
    localparam logic [VCW-1:0] V_LAST   = VCW'(VTOT - 1);
    localparam logic [VCW-1:0] V_SYNC_B = VCW'(VFP);
    localparam logic [VCW-1:0] V_SYNC_E = VCW'(VFP + VPULSE);
    localparam logic [VCW-1:0] V_ACT    = VCW'(VFP + VPULSE + VBP);

    logic [HCW-1:0] h_cnt_q, h_cnt_d;
    logic [VCW-1:0] v_cnt_q, v_cnt_d;

    always_comb begin
        h_cnt_d = h_cnt_q + HCW'(1);
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VCW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign hsync_o    = (h_cnt_q >= H_SYNC_B) && (h_cnt_q < H_SYNC_E);
    assign vsync_o    = (v_cnt_q >= V_SYNC_B) && (v_cnt_q < V_SYNC_E);
    assign active_o   = (h_cnt_q >= H_ACT) && (v_cnt_q >= V_ACT);
    assign origin_o   = (h_cnt_q == '0) && (v_cnt_q == '0);
    assign first_px_o = (h_cnt_q == H_ACT) && (v_cnt_q == V_ACT);
    assign x_o        = active_o ? XW'(h_cnt_q - H_ACT) : '0;
    assign y_o        = active_o ? YW'(v_cnt_q - V_ACT) : '0;

endmodule

// File: rtl/vga_stream_out.sv
// Streams frame-aligned pixel words onto a VGA raster with underflow/misalignment recovery.
// Optional macro VGA_TEST_PATTERN_EN adds pattern_sel, which overrides the stream with colour bars.
module vga_stream_out
    import vga_pkg::*;
#(
    parameter int   HDISP      = 800,
    parameter int   VDISP      = 480,
    parameter int   HFP        = 40,
    parameter int   HPULSE     = 48,
    parameter int   HBP        = 40,
    parameter int   VFP        = 13,
    parameter int   VPULSE     = 3,
    parameter int   VBP        = 29,
    parameter logic HS_POL     = 1'b0,
    parameter logic VS_POL     = 1'b0,
    parameter int   DATA_WIDTH = 32,
    localparam int  XW         = (HDISP > 1) ? $clog2(HDISP) : 1,
    localparam int  YW         = (VDISP > 1) ? $clog2(VDISP) : 1
) (
    input  logic                  pixel_clk,
    input  logic                  pixel_rst,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] pix_data,
    input  logic                  pix_valid,
    input  logic                  pix_sof,
`ifdef VGA_TEST_PATTERN_EN
    input  logic                  pattern_sel,
`endif
    output logic                  pix_ready,
    output logic                  vid_hs,
    output logic                  vid_vs,
    output logic                  vid_blank,
    output logic [DATA_WIDTH-1:0] vid_rgb,
    output logic [XW-1:0]         vid_x,
    output logic [YW-1:0]         vid_y,
    output logic                  frame_start,
    output logic                  underflow,
    output logic [15:0]           err_cnt
);

    logic          t_hs, t_vs, t_active, t_origin, t_first;
    logic [XW-1:0] t_x;
    logic [YW-1:0] t_y;

    vga_timing #(
        .HDISP(HDISP), .VDISP(VDISP),
        .HFP(HFP), .HPULSE(HPULSE), .HBP(HBP),
        .VFP(VFP), .VPULSE(VPULSE), .VBP(VBP),
        .XW(XW), .YW(YW)
    ) u_timing (
        .clk_i     (pixel_clk),
        .rst_i     (pixel_rst),
        .hsync_o   (t_hs),
        .vsync_o   (t_vs),
        .active_o  (t_active),
        .origin_o  (t_origin),
        .first_px_o(t_first),
        .x_o       (t_x),
        .y_o       (t_y)
    );

    vga_state_e            state_q, state_d;
    logic                  err_hit;
    logic [DATA_WIDTH-1:0] rgb_q, rgb_d;
    logic                  hs_q, vs_q, blank_q, fs_q, uf_q;
    logic [XW-1:0]         x_q;
    logic [YW-1:0]         y_q;
    logic [15:0]           err_cnt_q, err_cnt_d;

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] bar_idx;
    assign bar_idx = 3'((int'(t_x) * NUM_BARS) / HDISP);
`endif

    always_comb begin
        state_d   = state_q;
        pix_ready = 1'b0;
        rgb_d     = '0;
        err_hit   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                pix_ready = pix_valid && !pix_sof;
                if (pix_valid && pix_sof) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (t_origin) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (t_active) begin
                    // The frame's first pixel must carry SOF; any other pixel must not.
                    pix_ready = t_first ? pix_sof : !pix_sof;
                    if (!pix_valid || !pix_ready) begin
                        err_hit = 1'b1;
                        state_d = ST_FLUSH;
                    end else begin
                        rgb_d = pix_data;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (!enable) state_d = ST_IDLE;
`ifdef VGA_TEST_PATTERN_EN
        if (pattern_sel) begin
            state_d   = state_q;
            pix_ready = 1'b0;
            err_hit   = 1'b0;
            rgb_d     = t_active ? DATA_WIDTH'(bar_colour(bar_idx)) : '0;
        end
`endif
    end

    assign err_cnt_d = (err_hit && (err_cnt_q != 16'hFFFF)) ? err_cnt_q + 16'd1 : err_cnt_q;

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            state_q   <= ST_IDLE;
            hs_q      <= ~HS_POL;
            vs_q      <= ~VS_POL;
            blank_q   <= 1'b0;
            rgb_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            fs_q      <= 1'b0;
            uf_q      <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            hs_q      <= t_hs ? HS_POL : ~HS_POL;
            vs_q      <= t_vs ? VS_POL : ~VS_POL;
            blank_q   <= t_active;
            rgb_q     <= rgb_d;
            x_q       <= t_x;
            y_q       <= t_y;
            fs_q      <= t_origin;
            uf_q      <= err_hit;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign vid_hs      = hs_q;
    assign vid_vs      = vs_q;
    assign vid_blank   = blank_q;
    assign vid_rgb     = rgb_q;
    assign vid_x       = x_q;
    assign vid_y       = y_q;
    assign frame_start = fs_q;
    assign underflow   = uf_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_vga_stream_out.sv
// Directed bench for vga_stream_out on a 7x5 raster (4x2 active, all porches/pulses 1).
module tb_vga_stream_out;

    localparam int DW = 32;

    logic          pixel_clk = 1'b0;
    logic          pixel_rst = 1'b1;
    logic          enable    = 1'b0;
    logic [DW-1:0] pix_data  = '0;
    logic          pix_valid = 1'b0;
    logic          pix_sof   = 1'b0;
    logic          pix_ready, vid_hs, vid_vs, vid_blank, frame_start, underflow;
    logic [DW-1:0] vid_rgb;
    logic [1:0]    vid_x;
    logic [0:0]    vid_y;
    logic [15:0]   err_cnt;

    always #5 pixel_clk = ~pixel_clk;

    vga_stream_out #(
        .HDISP(4), .VDISP(2),
        .HFP(1), .HPULSE(1), .HBP(1),
        .VFP(1), .VPULSE(1), .VBP(1),
        .HS_POL(1'b0), .VS_POL(1'b0),
        .DATA_WIDTH(DW)
    ) dut (
        .pixel_clk  (pixel_clk),
        .pixel_rst  (pixel_rst),
        .enable     (enable),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_sof    (pix_sof),
`ifdef VGA_TEST_PATTERN_EN
        .pattern_sel(1'b0),
`endif
        .pix_ready  (pix_ready),
        .vid_hs     (vid_hs),
        .vid_vs     (vid_vs),
        .vid_blank  (vid_blank),
        .vid_rgb    (vid_rgb),
        .vid_x      (vid_x),
        .vid_y      (vid_y),
        .frame_start(frame_start),
        .underflow  (underflow),
        .err_cnt    (err_cnt)
    );

    typedef struct packed {
        logic          sof;
        logic [DW-1:0] d;
    } word_t;

    word_t q[$];
    logic  hold   = 1'b0;
    int    cyc    = 0;
    int    n_pass = 0;
    int    n_fail = 0;
    int    n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic drive();
        pix_valid = (q.size() != 0) && !hold;
        pix_data  = (q.size() != 0) ? q[0].d : '0;
        pix_sof   = (q.size() != 0) ? q[0].sof : 1'b0;
    endtask

    task automatic push(input logic [DW-1:0] d, input logic sof);
        q.push_back({sof, d});
    endtask

    // One clock: handshake decided on settled inputs, then outputs settle at edge+1.
    task automatic tick();
        logic fire;
        drive();
        #1;
        fire = pix_valid && pix_ready;
        @(posedge pixel_clk);
        #1;
        cyc++;
        if (fire) void'(q.pop_front());
        drive();
        #1;
    endtask

    task automatic advance_to(input int n);
        while (cyc < n) tick();
    endtask

    initial begin
        int h, v, hs_lo, vs_lo, fs_n;

        // Reset state
        repeat (2) @(posedge pixel_clk);
        #1;
        chk("rst_hs", vid_hs, 1);
        chk("rst_vs", vid_vs, 1);
        chk("rst_blank", vid_blank, 0);
        chk("rst_rgb", vid_rgb, 0);
        chk("rst_fs", frame_start, 0);
        chk("rst_uf", underflow, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_ready", pix_ready, 0);
        pixel_rst = 1'b0;

        // Free-running timing, stream disabled
        hs_lo = 0; vs_lo = 0; fs_n = 0;
        for (int n = 1; n <= 36; n++) begin
            tick();
            h = (n - 1) % 7;
            v = ((n - 1) / 7) % 5;
            chk("hs_seq", vid_hs, (h == 1) ? 0 : 1);
            chk("vs_seq", vid_vs, (v == 1) ? 0 : 1);
            chk("fs_seq", frame_start, (h == 0 && v == 0) ? 1 : 0);
            if (n <= 35) begin
                if (!vid_hs) hs_lo++;
                if (!vid_vs) vs_lo++;
                if (frame_start) fs_n++;
            end
        end
        chk("hs_low_per_frame", hs_lo, 5);
        chk("vs_low_per_frame", vs_lo, 7);
        chk("fs_per_frame", fs_n, 1);
        chk("idle_ready", pix_ready, 0);
        chk("idle_rgb", vid_rgb, 0);

        // Junk, then two aligned frames
        for (int i = 0; i < 3; i++) push(32'hDEAD_0000 + i, 1'b0);
        for (int i = 0; i < 8; i++) push(32'hA0 + i, (i == 0));
        for (int i = 0; i < 8; i++) push(32'hB0 + i, (i == 0));
        enable = 1'b1;
        advance_to(37); chk("flush_drop0", pix_ready, 1);
        advance_to(38); chk("flush_drop1", pix_ready, 1);
        advance_to(39); chk("flush_drop2", pix_ready, 1);
        advance_to(40); chk("flush_hold_sof", pix_ready, 0);
        advance_to(41); chk("armed_ready", pix_ready, 0);
        advance_to(94); chk("rgb_pre_active", vid_rgb, 0);
        for (int i = 0; i < 8; i++) begin
            advance_to((i < 4) ? 95 + i : 98 + i);
            chk("f1_rgb", vid_rgb, 32'hA0 + i);
            chk("f1_x", vid_x, i % 4);
            chk("f1_y", vid_y, i / 4);
            chk("f1_blank", vid_blank, 1);
        end
        advance_to(106);
        chk("f1_rgb_blanking", vid_rgb, 0);
        chk("f1_err", err_cnt, 0);

        // Withhold the word at x=2, y=1 of the second frame
        advance_to(138);
        chk("f2_rgb_x1y1", vid_rgb, 32'hB5);
        hold = 1'b1;
        tick();
        hold = 1'b0;
        drive();
        #1;
        chk("uf_rgb", vid_rgb, 0);
        chk("uf_pulse", underflow, 1);
        chk("uf_err", err_cnt, 1);
        chk("uf_x", vid_x, 2);
        chk("uf_y", vid_y, 1);
        tick();
        chk("uf_pulse_end", underflow, 0);
        chk("uf_flush_rgb", vid_rgb, 0);
        chk("uf_flush_ready", pix_ready, 1);
        advance_to(141);

        // SOF on the x=1, y=0 word
        push(32'hC0, 1'b1);
        push(32'hC1, 1'b1);
        for (int i = 2; i < 9; i++) push(32'hC0 + i, 1'b0);
        drive();
        #1;
        advance_to(200);
        chk("f3_rgb0", vid_rgb, 32'hC0);
        chk("mis_ready", pix_ready, 0);
        tick();
        chk("mis_rgb", vid_rgb, 0);
        chk("mis_pulse", underflow, 1);
        chk("mis_err", err_cnt, 2);
        chk("mis_flush_ready", pix_ready, 0);
        for (int i = 0; i < 8; i++) begin
            advance_to((i < 4) ? 235 + i : 238 + i);
            chk("f4_rgb", vid_rgb, 32'hC1 + i);
            chk("f4_x", vid_x, i % 4);
        end
        chk("f4_err", err_cnt, 2);
        enable = 1'b0;
        advance_to(250);
        chk("disabled_ready", pix_ready, 0);

        // Saturation of the error counter
        push(32'hD0, 1'b1);
        enable = 1'b1;
        advance_to(290);
        force dut.err_cnt_q = 16'hFFFF;
        tick();
        release dut.err_cnt_q;
        #1;
        chk("sat_preload", err_cnt, 16'hFFFF);
        advance_to(304);
        hold = 1'b1;
        tick();
        hold = 1'b0;
        drive();
        #1;
        chk("sat_uf_pulse", underflow, 1);
        chk("sat_err", err_cnt, 16'hFFFF);

        // Asynchronous reset mid-line
        tick();
        chk("pre_rst_x", vid_x, 1);
        chk("pre_rst_blank", vid_blank, 1);
        #2;
        pixel_rst = 1'b1;
        #1;
        chk("arst_err", err_cnt, 0);
        chk("arst_blank", vid_blank, 0);
        chk("arst_x", vid_x, 0);
        chk("arst_hs", vid_hs, 1);
        chk("arst_vs", vid_vs, 1);
        chk("arst_rgb", vid_rgb, 0);
        chk("arst_uf", underflow, 0);
        chk("arst_ready", pix_ready, 0);
        @(posedge pixel_clk);
        #1;
        pixel_rst = 1'b0;
        cyc = 0;
        tick();
        chk("restart_fs", frame_start, 1);
        chk("restart_hs", vid_hs, 1);
        tick();
        chk("restart_hs_pulse", vid_hs, 0);
        chk("restart_fs_end", frame_start, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
